// File: rtl/operand_gen.sv
// Burst operand-pair generator feeding the operand-capture stage (const/incr/lfsr/cross patterns).
// Define OPERAND_GEN_STALL_EN to add the stall_i port that pauses a burst without losing elements.
module operand_gen #(
  parameter int unsigned CNT_W  = 16,
  parameter logic [7:0]  SEED_A = 8'hA5,
  parameter logic [7:0]  SEED_B = 8'h5A
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
`ifdef OPERAND_GEN_STALL_EN
  input  logic             stall_i,
`endif
  input  logic [1:0]       mode_i,
  input  logic [CNT_W-1:0] count_i,
  input  logic [7:0]       a_init_i,
  input  logic [7:0]       b_init_i,
  output logic [7:0]       a_o,
  output logic [7:0]       b_o,
  output logic             valid_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic {IDLE, RUN} state_t;
  typedef enum logic [1:0] {M_CONST = 2'd0, M_INCR = 2'd1, M_LFSR = 2'd2, M_CROSS = 2'd3} mode_t;

  state_t           state;
  mode_t            mode_q;
  logic [CNT_W-1:0] remaining;
  logic             stall;
  logic [7:0]       a_load;
  logic [7:0]       b_load;
  logic [7:0]       a_next;
  logic [7:0]       b_next;

`ifdef OPERAND_GEN_STALL_EN
  assign stall = stall_i;
`else
  assign stall = 1'b0;
`endif

  function automatic logic [7:0] lfsr_next(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
  endfunction

  // A zero seed would lock the LFSR at zero forever, so substitute the seed parameter.
  always_comb begin
    a_load = a_init_i;
    b_load = b_init_i;
    if (mode_t'(mode_i) == M_LFSR) begin
      if (a_init_i == 8'd0) a_load = SEED_A;
      if (b_init_i == 8'd0) b_load = SEED_B;
    end
  end

  always_comb begin
    a_next = a_o;
    b_next = b_o;
    case (mode_q)
      M_CONST: begin
        a_next = a_o;
        b_next = b_o;
      end
      M_INCR: begin
        a_next = a_o + 8'd1;
        b_next = b_o + 8'd1;
      end
      M_LFSR: begin
        a_next = lfsr_next(a_o);
        b_next = lfsr_next(b_o);
      end
      M_CROSS: begin
        a_next = a_o + 8'd1;
        b_next = b_o - 8'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mode_q    <= M_CONST;
      remaining <= '0;
      a_o       <= 8'd0;
      b_o       <= 8'd0;
      valid_o   <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          valid_o <= 1'b0;
          busy_o  <= 1'b0;
          if (start_i) begin
            if (count_i != '0) begin
              mode_q    <= mode_t'(mode_i);
              a_o       <= a_load;
              b_o       <= b_load;
              remaining <= count_i - CNT_W'(1);
              valid_o   <= 1'b1;
              busy_o    <= 1'b1;
              state     <= RUN;
            end else begin
              done_o <= 1'b1;
            end
          end
        end
        RUN: begin
          // A stall freezes the sequence; the held element is not counted again.
          if (stall) begin
            valid_o <= 1'b0;
          end else if (remaining != '0) begin
            a_o       <= a_next;
            b_o       <= b_next;
            remaining <= remaining - CNT_W'(1);
            valid_o   <= 1'b1;
          end else begin
            valid_o <= 1'b0;
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_gen.sv
// Directed, table-driven bench for operand_gen, plus hand sequences for reset, stall and max-count corners.
module tb_operand_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_i;
  logic       stall_i;
  logic [1:0] mode_i;
  logic [15:0] count_i;
  logic [7:0] a_init_i;
  logic [7:0] b_init_i;
  logic [7:0] a_o;
  logic [7:0] b_o;
  logic       valid_o;
  logic       busy_o;
  logic       done_o;

  logic       start2;
  logic [3:0] count2;
  logic [7:0] a2;
  logic [7:0] b2;
  logic       valid2;
  logic       busy2;
  logic       done2;

  int testsRun    = 0;
  int testsFailed = 0;
  logic [7:0] prevA;
  logic [7:0] prevB;

  always #5 clk = ~clk;

  operand_gen dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
`ifdef OPERAND_GEN_STALL_EN
    .stall_i  (stall_i),
`endif
    .mode_i   (mode_i),
    .count_i  (count_i),
    .a_init_i (a_init_i),
    .b_init_i (b_init_i),
    .a_o      (a_o),
    .b_o      (b_o),
    .valid_o  (valid_o),
    .busy_o   (busy_o),
    .done_o   (done_o)
  );

  // Narrow counter instance so a maximum-length burst stays short.
  operand_gen #(.CNT_W(4)) dutSmall (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start2),
`ifdef OPERAND_GEN_STALL_EN
    .stall_i  (1'b0),
`endif
    .mode_i   (mode_i),
    .count_i  (count2),
    .a_init_i (a_init_i),
    .b_init_i (b_init_i),
    .a_o      (a2),
    .b_o      (b2),
    .valid_o  (valid2),
    .busy_o   (busy2),
    .done_o   (done2)
  );

  typedef struct {
    string       name;
    logic [1:0]  mode;
    logic [15:0] count;
    logic [7:0]  aInit;
    logic [7:0]  bInit;
    logic [63:0] expA;
    logic [63:0] expB;
  } vec_t;

  vec_t vecs[7];

  function automatic vec_t mkVec(input string name, input logic [1:0] mode, input logic [15:0] count,
                                 input logic [7:0] aInit, input logic [7:0] bInit,
                                 input logic [63:0] expA, input logic [63:0] expB);
    vec_t v;
    v.name  = name;
    v.mode  = mode;
    v.count = count;
    v.aInit = aInit;
    v.bInit = bInit;
    v.expA  = expA;
    v.expB  = expB;
    return v;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] mode, input logic [15:0] count,
                               input logic [7:0] aInit, input logic [7:0] bInit);
    mode_i   = mode;
    count_i  = count;
    a_init_i = aInit;
    b_init_i = bInit;
    start_i  = 1'b1;
  endtask

  task automatic checkOutput(input string name, input logic v, input logic bsy, input logic d,
                             input logic [7:0] ea, input logic [7:0] eb);
    testsRun++;
    if (valid_o !== v || busy_o !== bsy || done_o !== d || a_o !== ea || b_o !== eb) begin
      testsFailed++;
      $display("[TB] FAIL %s: got v=%0b busy=%0b done=%0b a=%02h b=%02h, want v=%0b busy=%0b done=%0b a=%02h b=%02h",
               name, valid_o, busy_o, done_o, a_o, b_o, v, bsy, d, ea, eb);
    end
  endtask

  task automatic checkValue(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
    end
  endtask

  initial begin
    rst      = 1'b1;
    start_i  = 1'b0;
    stall_i  = 1'b0;
    mode_i   = 2'd0;
    count_i  = 16'd0;
    a_init_i = 8'd0;
    b_init_i = 8'd0;
    start2   = 1'b0;
    count2   = 4'd0;

    vecs[0] = mkVec("incr",       2'd1, 16'd3, 8'd10,  8'd20,
                    {8'd10, 8'd11, 8'd12, 40'd0}, {8'd20, 8'd21, 8'd22, 40'd0});
    vecs[1] = mkVec("cross_wrap", 2'd3, 16'd4, 8'd254, 8'd1,
                    {8'hFE, 8'hFF, 8'h00, 8'h01, 32'd0}, {8'h01, 8'h00, 8'hFF, 8'hFE, 32'd0});
    vecs[2] = mkVec("lfsr_seedB", 2'd2, 16'd5, 8'h01,  8'h00,
                    {8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 24'd0}, {8'h5A, 8'hB4, 8'h69, 8'hD2, 8'hA4, 24'd0});
    vecs[3] = mkVec("const",      2'd0, 16'd2, 8'd7,   8'd9,
                    {8'd7, 8'd7, 48'd0}, {8'd9, 8'd9, 48'd0});
    vecs[4] = mkVec("count_zero", 2'd1, 16'd0, 8'd50,  8'd60, 64'd0, 64'd0);
    vecs[5] = mkVec("incr_wrap",  2'd1, 16'd3, 8'hFF,  8'hFE,
                    {8'hFF, 8'h00, 8'h01, 40'd0}, {8'hFE, 8'hFF, 8'h00, 40'd0});
    vecs[6] = mkVec("lfsr_seedA", 2'd2, 16'd3, 8'h00,  8'h80,
                    {8'hA5, 8'h4A, 8'h95, 40'd0}, {8'h80, 8'h01, 8'h02, 40'd0});

    tick;
    tick;
    checkOutput("reset_state", 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    rst   = 1'b0;
    prevA = 8'd0;
    prevB = 8'd0;
    tick;

    // Each burst's start is driven on the previous burst's done cycle, so back-to-back launch is covered.
    for (int k = 0; k < 7; k++) begin
      applyStimulus(vecs[k].mode, vecs[k].count, vecs[k].aInit, vecs[k].bInit);
      tick;
      start_i = 1'b0;
      for (int i = 0; i < int'(vecs[k].count); i++) begin
        prevA = vecs[k].expA[63-8*i -: 8];
        prevB = vecs[k].expB[63-8*i -: 8];
        checkOutput($sformatf("%s_elem%0d", vecs[k].name, i), 1'b1, 1'b1, 1'b0, prevA, prevB);
        tick;
      end
      checkOutput($sformatf("%s_done", vecs[k].name), 1'b0, 1'b0, 1'b1, prevA, prevB);
    end
    tick;
    checkOutput("done_single_pulse", 1'b0, 1'b0, 1'b0, prevA, prevB);

    applyStimulus(2'd1, 16'd3, 8'd10, 8'd20);
    tick;
    checkOutput("ignore_start_e0", 1'b1, 1'b1, 1'b0, 8'd10, 8'd20);
    applyStimulus(2'd0, 16'd1, 8'd99, 8'd98);
    tick;
    checkOutput("ignore_start_e1", 1'b1, 1'b1, 1'b0, 8'd11, 8'd21);
    tick;
    start_i = 1'b0;
    checkOutput("ignore_start_e2", 1'b1, 1'b1, 1'b0, 8'd12, 8'd22);
    tick;
    checkOutput("ignore_start_done", 1'b0, 1'b0, 1'b1, 8'd12, 8'd22);
    tick;

    applyStimulus(2'd1, 16'd10, 8'd0, 8'd0);
    tick;
    start_i = 1'b0;
    tick;
    tick;
    checkOutput("midburst_running", 1'b1, 1'b1, 1'b0, 8'd2, 8'd2);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      checkOutput($sformatf("midburst_reset%0d", i), 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    end
    rst = 1'b0;
    tick;
    checkOutput("after_reset_no_done", 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    applyStimulus(2'd1, 16'd1, 8'd5, 8'd6);
    tick;
    start_i = 1'b0;
    checkOutput("after_reset_elem", 1'b1, 1'b1, 1'b0, 8'd5, 8'd6);
    tick;
    checkOutput("after_reset_done", 1'b0, 1'b0, 1'b1, 8'd5, 8'd6);
    tick;

`ifdef OPERAND_GEN_STALL_EN
    applyStimulus(2'd1, 16'd4, 8'd0, 8'd0);
    tick;
    start_i = 1'b0;
    checkOutput("stall_e0", 1'b1, 1'b1, 1'b0, 8'd0, 8'd0);
    tick;
    checkOutput("stall_e1", 1'b1, 1'b1, 1'b0, 8'd1, 8'd1);
    stall_i = 1'b1;
    tick;
    checkOutput("stall_gap0", 1'b0, 1'b1, 1'b0, 8'd1, 8'd1);
    tick;
    checkOutput("stall_gap1", 1'b0, 1'b1, 1'b0, 8'd1, 8'd1);
    stall_i = 1'b0;
    tick;
    checkOutput("stall_e2", 1'b1, 1'b1, 1'b0, 8'd2, 8'd2);
    tick;
    checkOutput("stall_e3", 1'b1, 1'b1, 1'b0, 8'd3, 8'd3);
    stall_i = 1'b1;
    tick;
    checkOutput("stall_final_hold", 1'b0, 1'b1, 1'b0, 8'd3, 8'd3);
    stall_i = 1'b0;
    tick;
    checkOutput("stall_done", 1'b0, 1'b0, 1'b1, 8'd3, 8'd3);
    tick;
`endif

    // Full-range count on the narrow instance: 15 elements, counter must not wrap.
    begin
      int nValid;
      int lastA;
      logic sawDone;
      nValid  = 0;
      lastA   = -1;
      sawDone = 1'b0;
      mode_i   = 2'd1;
      a_init_i = 8'd0;
      b_init_i = 8'd0;
      count2   = 4'd15;
      start2   = 1'b1;
      tick;
      start2 = 1'b0;
      for (int c = 0; c < 40 && !sawDone; c++) begin
        if (valid2) begin
          nValid++;
          lastA = int'(a2);
        end
        if (done2) sawDone = 1'b1;
        else tick;
      end
      checkValue("maxcount_valid_cycles", nValid, 15);
      checkValue("maxcount_last_a", lastA, 14);
      checkValue("maxcount_done_seen", int'(sawDone), 1);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
